// File: rtl/par_ser_sched.sv
// Purpose: two-requester byte scheduler feeding a parallel-to-serial converter, one byte slot per 8 enabled clocks.
// Latency: a byte transferred at a slot boundary appears on ser_data with ser_load one clock later.
// Backpressure: reqX_ready is raised only at a slot boundary for the selected requester; idle slots carry IDLE_SYM filler.
module par_ser_sched #(
    parameter logic [7:0] IDLE_SYM  = 8'h7C,
    parameter int         MAX_STALL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       ser_load,
    output logic [7:0] ser_data,
    output logic       ser_k,
    output logic [1:0] grant,
    output logic [2:0] bit_cnt,
    output logic       abort
);

    localparam int SW = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t          state_q;
    logic [2:0]      bit_cnt_q;
    logic [SW-1:0]   stall_q;
    logic            last_q;       // requester that ended the most recent packet
    logic            load_pend_q;  // a fresh byte is waiting to be presented to the converter
    logic [7:0]      ser_data_q;
    logic            ser_k_q;
    logic [1:0]      grant_q;
    logic            abort_q;

    logic            boundary;
    logic            sel_vld;
    logic            sel_id;
    logic [7:0]      sel_data;
    logic            sel_last;
    logic            stall_hit;

    assign boundary = enb && (bit_cnt_q == 3'd7);

    // Pick the requester that would be served if this cycle were a slot boundary.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0_valid && req1_valid) begin
                    sel_vld = 1'b1;
                    sel_id  = ~last_q;
                end else if (req0_valid) begin
                    sel_vld = 1'b1;
                    sel_id  = 1'b0;
                end else if (req1_valid) begin
                    sel_vld = 1'b1;
                    sel_id  = 1'b1;
                end
            end
            S_OWN0: begin
                sel_vld = req0_valid;
                sel_id  = 1'b0;
            end
            S_OWN1: begin
                sel_vld = req1_valid;
                sel_id  = 1'b1;
            end
            default: begin
                sel_vld = 1'b0;
                sel_id  = 1'b0;
            end
        endcase
    end

    assign sel_data   = sel_id ? req1_data : req0_data;
    assign sel_last   = sel_id ? req1_last : req0_last;
    assign req0_ready = boundary && sel_vld && !sel_id;
    assign req1_ready = boundary && sel_vld && sel_id;

    // Owner has already caused MAX_STALL-1 fillers and is about to cause another.
    assign stall_hit  = (state_q != S_IDLE) && !sel_vld && (stall_q == SW'(MAX_STALL - 1));

    // Slot counter, ownership FSM and registered converter outputs; everything freezes while enb is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            stall_q     <= '0;
            last_q      <= 1'b1;
            load_pend_q <= 1'b0;
            ser_data_q  <= IDLE_SYM;
            ser_k_q     <= 1'b1;
            grant_q     <= 2'b00;
            abort_q     <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            if (enb) begin
                bit_cnt_q   <= bit_cnt_q + 3'd1;
                load_pend_q <= boundary;
                if (boundary) begin
                    if (sel_vld) begin
                        ser_data_q <= sel_data;
                        ser_k_q    <= 1'b0;
                        stall_q    <= '0;
                        if (sel_last) begin
                            state_q <= S_IDLE;
                            grant_q <= 2'b00;
                            last_q  <= sel_id;
                        end else begin
                            state_q <= sel_id ? S_OWN1 : S_OWN0;
                            grant_q <= sel_id ? 2'b10 : 2'b01;
                        end
                    end else begin
                        ser_data_q <= IDLE_SYM;
                        ser_k_q    <= 1'b1;
                        if (state_q != S_IDLE) begin
                            if (stall_hit) begin
                                state_q <= S_IDLE;
                                grant_q <= 2'b00;
                                abort_q <= 1'b1;
                                stall_q <= '0;
                                last_q  <= (state_q == S_OWN1);
                            end else begin
                                stall_q <= stall_q + SW'(1);
                            end
                        end
                    end
                end
            end
        end
    end

    // The pending load is only shown on an enabled cycle so the converter never sees it while frozen.
    assign ser_load = load_pend_q && enb;
    assign ser_data = ser_data_q;
    assign ser_k    = ser_k_q;
    assign grant    = grant_q;
    assign bit_cnt  = bit_cnt_q;
    assign abort    = abort_q;

endmodule

// File: doc/par_ser_sched.md
PAR_SER_SCHED -- requirements
Module: par_ser_sched

Interface
REQ-001 Parameter: IDLE_SYM, default 8'h7C, filler byte sent when no requester owns the lane.
REQ-002 Parameter: MAX_STALL, default 4, consecutive filler slots an owner may cause before it is aborted.
REQ-003 Port: clk  in  1  bit clock; one serial bit per cycle; all logic on posedge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: enb  in  1  global enable; low freezes all state.
REQ-006 Port: req0_valid  in  1  requester 0 has a byte.
REQ-007 Port: req0_data  in  8  requester 0 byte.
REQ-008 Port: req0_last  in  1  byte is the last of requester 0's packet.
REQ-009 Port: req0_ready  out  1  requester 0 byte accepted this cycle.
REQ-010 Ports: req1_valid, req1_data[7:0], req1_last, req1_ready; same meaning for requester 1.
REQ-011 Port: ser_load  out  1  one-cycle strobe; parallel-serial converter loads ser_data.
REQ-012 Port: ser_data  out  8  byte for the converter.
REQ-013 Port: ser_k  out  1  ser_data is IDLE_SYM filler, not requester data.
REQ-014 Port: grant  out  2  one-hot current owner; 00 when none.
REQ-015 Port: bit_cnt  out  3  bit position within the current byte slot.
REQ-016 Port: abort  out  1  one-cycle pulse when an owner is dropped for stalling.

Function
REQ-017 bit_cnt SHALL increment by 1 each clk with enb=1, wrapping 7->0; slot boundary = enb && bit_cnt==7.
REQ-018 reqX_ready SHALL be combinational: high only at a slot boundary for the requester selected in REQ-020..023; a transfer is valid && ready.
REQ-019 At every slot boundary, ser_data/ser_k SHALL register the selected byte (or IDLE_SYM with ser_k=1), and ser_load SHALL be 1 in the following cycle (bit_cnt==0) only; one byte per 8 enabled cycles; latency from transfer to ser_load is 1 clk.
REQ-020 FSM states: IDLE, OWN0, OWN1; grant = 00/01/10 respectively.
REQ-021 IDLE at boundary: one valid -> serve it; both valid -> serve the requester not served last (rr pointer); none -> filler, stay IDLE.
REQ-022 Served byte in IDLE with last=0 -> enter OWNx; with last=1 -> stay IDLE; rr pointer updated to x on every packet end.
REQ-023 OWNx at boundary: reqx_valid -> serve reqx only (other requester never ready), clear stall count; last=1 -> IDLE, pointer=x.
REQ-024 OWNx with reqx_valid=0 at boundary: send filler, stall_cnt+1; when stall_cnt reaches MAX_STALL, go IDLE, pulse abort 1 cycle, pointer=x, stall_cnt=0.
REQ-025 enb=0: bit_cnt, FSM, stall_cnt, pointer held; all ready=0; ser_load=0; ser_data/ser_k held.
REQ-026 valid falling without a transfer SHALL not change state; data is sampled only at transfer.
REQ-027 Single-byte packets (last=1 on first byte) from both requesters SHALL alternate 0,1,0,1 when both stay valid.

Reset
REQ-028 reset=0 SHALL asynchronously force: bit_cnt=0, state IDLE, grant=00, ser_data=IDLE_SYM, ser_k=1, ser_load=0, abort=0, stall_cnt=0, pointer favouring requester 0 first.
REQ-029 Reset asserted mid-packet SHALL drop ownership; the packet is not resumed; first boundary after release follows REQ-021.
REQ-030 Release of reset SHALL take effect at the next posedge; first slot boundary occurs 8 enabled cycles later.

Verification
REQ-031 Idle lane: no valid, enb=1 for 32 cycles -> ser_load at bit_cnt==0 every 8 cycles, ser_data=8'h7C, ser_k=1, grant=00.
REQ-032 Req0 packet E6,0D,5D (last on 5D) -> three consecutive ser_load with those bytes, ser_k=0, grant=01 after E6, 00 after 5D.
REQ-033 Both valid, single-byte packets A1 (req0) and B2 (req1) held -> ser_data sequence A1,B2,A1,B2.
REQ-034 Req1 owns, then req1_valid drops for 4 slots -> four 7C fillers with ser_k=1, abort pulse at 4th boundary, grant=00, next boundary serves pending req0.
REQ-035 enb low for 5 cycles at bit_cnt==3 -> bit_cnt stays 3, no ready/ser_load; resumes counting 4..7 after enb returns.
REQ-036 reset pulled low at bit_cnt==5 during req0 packet -> outputs immediately per REQ-028; after release req0 remaining bytes arbitrate as new packet from IDLE.
